// File: rtl/icache_sa_if.sv
// -----------------------------------------------------------------------------
// icache_sa_if -- refill bus between the instruction cache and backing memory.
//
// Signals:
//   mem_bus_address  cache -> mem  32   line-aligned refill address
//   mem_read_start   cache -> mem  1    refill request (held for the whole refill)
//   mem_bus_data     mem -> cache  128  refill line, word k at bits [32k+31:32k]
//   mem_read_rdy     mem -> cache  1    refill line valid this cycle
//
// Modports: master = cache side, slave = memory side.
// -----------------------------------------------------------------------------
interface icache_sa_if;
    logic [31:0]  mem_bus_address;
    logic         mem_read_start;
    logic [127:0] mem_bus_data;
    logic         mem_read_rdy;

    modport master (
        output mem_bus_address,
        output mem_read_start,
        input  mem_bus_data,
        input  mem_read_rdy
    );

    modport slave (
        input  mem_bus_address,
        input  mem_read_start,
        output mem_bus_data,
        output mem_read_rdy
    );
endinterface

// File: rtl/icache_sa.sv
// -----------------------------------------------------------------------------
// icache_sa -- two-way set-associative instruction cache, 128-bit lines.
//
// Ports:
//   clk         in   1    clock, rising edge
//   reset       in   1    asynchronous, active-low
//   cs          in   1    lookup enable
//   address     in   32   fetch byte address (bits [1:0] ignored)
//   data        out  32   fetched word, 0 when not hitting
//   hit         out  1    combinational hit, data valid this cycle
//   invalidate  in   1    clear all lines (fence.i)
//   busy        out  1    refill outstanding
//   mem         icache_sa_if.master   refill bus
//   hit_count   out  32   saturating hit-cycle counter   (ICACHE_PERF_CNT_EN)
//   miss_count  out  32   saturating refill-start counter (ICACHE_PERF_CNT_EN)
//
// Configuration macro: ICACHE_PERF_CNT_EN adds the performance counters.
// Parameter SETS: number of sets, power of two, at least 2.
// -----------------------------------------------------------------------------
module icache_sa #(
    parameter int unsigned SETS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic [31:0]        address,
    output logic [31:0]        data,
    output logic               hit,
    input  logic               invalidate,
    output logic               busy,
    icache_sa_if.master        mem
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, state_next;

    // Lookup address fields
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       unused_addr;

    assign off         = address[3:2];
    assign idx         = address[4 +: IDX_W];
    assign tag         = address[31 -: TAG_W];
    assign unused_addr = address[1:0];

    // Storage: tag/data arrays are not reset, valid and LRU are
    logic [TAG_W-1:0] tag_mem  [2][SETS];
    logic [127:0]     data_mem [2][SETS];
    logic [SETS-1:0]  valid0, valid1;
    logic [SETS-1:0]  lru;              // per set: way to evict next

    // Refill bookkeeping
    logic [27:0]      line_addr;
    logic             inv_pending;      // invalidate seen during this refill
    logic             line_load;
    logic             install;

    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             victim;

    assign r_idx = line_addr[IDX_W-1:0];
    assign r_tag = line_addr[27 -: TAG_W];

    // ---------------- lookup ----------------
    logic [1:0]   way_hit;
    logic         lookup_en;
    logic [127:0] hit_line;

    assign way_hit[0] = valid0[idx] && (tag_mem[0][idx] == tag);
    assign way_hit[1] = valid1[idx] && (tag_mem[1][idx] == tag);
    assign lookup_en  = cs && (state == IDLE) && !invalidate;
    assign hit        = lookup_en && (|way_hit);

    always_comb begin
        hit_line = way_hit[0] ? data_mem[0][idx] : data_mem[1][idx];
        data     = '0;
        if (hit) begin
            data = hit_line[{off, 5'b0} +: 32];
        end
    end

    // Victim: first invalid way (way0 preferred), else the LRU way
    always_comb begin
        if (!valid0[r_idx]) begin
            victim = 1'b0;
        end else if (!valid1[r_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru[r_idx];
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        line_load  = 1'b0;
        install    = 1'b0;
        case (state)
            IDLE: begin
                if (cs && !hit && !invalidate) begin
                    state_next = REFILL;
                    line_load  = 1'b1;
                end
            end
            REFILL: begin
                if (mem.mem_read_rdy) begin
                    state_next = IDLE;
                    // Handshake always completes; the line is dropped if an
                    // invalidate overlapped any part of the refill.
                    install    = !invalidate && !inv_pending;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_addr   <= '0;
            inv_pending <= 1'b0;
            valid0      <= '0;
            valid1      <= '0;
            lru         <= '0;
        end else begin
            if (line_load) begin
                line_addr   <= address[31:4];
                inv_pending <= 1'b0;
            end else if ((state == REFILL) && invalidate) begin
                inv_pending <= 1'b1;
            end

            // After a hit, evict the other way next time
            if (hit) begin
                lru[idx] <= way_hit[0];
            end

            if (install) begin
                if (victim) begin
                    valid1[r_idx] <= 1'b1;
                end else begin
                    valid0[r_idx] <= 1'b1;
                end
                lru[r_idx] <= ~victim;
            end

            if (invalidate) begin
                valid0 <= '0;
                valid1 <= '0;
            end
        end
    end

    // install is only possible in REFILL, which reset forces away
    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[victim][r_idx]  <= r_tag;
            data_mem[victim][r_idx] <= mem.mem_bus_data;
        end
    end

    // ---------------- outputs ----------------
    assign busy                = (state == REFILL);
    assign mem.mem_read_start  = busy;
    assign mem.mem_bus_address = {line_addr, 4'b0};

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (line_load && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// -----------------------------------------------------------------------------
// tb_icache_sa -- scoreboard bench for icache_sa.
// A stimulus process drives one cycle at a time, asks a line-level reference
// model (cache held as whole line addresses per set, plus most-recently-used
// way) for the outputs expected in that cycle and queues them; a monitor pops
// and compares on every falling edge.
// Counter checks are included when ICACHE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_icache_sa;

    localparam int SETS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [31:0] address;
    logic [31:0] data;
    logic        hit;
    logic        invalidate;
    logic        busy;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_sa_if bus ();

    icache_sa #(.SETS(SETS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .address    (address),
        .data       (data),
        .hit        (hit),
        .invalidate (invalidate),
        .busy       (busy),
        .mem        (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit           m_valid [SETS][2];
    logic [27:0]  m_line  [SETS][2];
    logic [127:0] m_data  [SETS][2];
    int           m_mru   [SETS];
    bit           m_pending;
    logic [27:0]  m_pline;
    bit           m_pinv;
    logic [31:0]  m_hits;
    logic [31:0]  m_misses;

    typedef struct {
        logic        hit;
        logic [31:0] data;
        logic        busy;
        logic        start;
        bit          chk_addr;
        logic [31:0] addr;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_mru[s]      = 1;   // makes way0 the first LRU victim
        end
        m_pending = 1'b0;
        m_pline   = '0;
        m_pinv    = 1'b0;
        m_hits    = '0;
        m_misses  = '0;
    endtask

    task automatic model_install(input logic [27:0] line, input logic [127:0] md);
        int s;
        int w;
        s = int'(line % SETS);
        if (!m_valid[s][0])      w = 0;
        else if (!m_valid[s][1]) w = 1;
        else                     w = 1 - m_mru[s];
        m_valid[s][w] = 1'b1;
        m_line[s][w]  = line;
        m_data[s][w]  = md;
        m_mru[s]      = w;
    endtask

    // One clock cycle of stimulus plus its expected response
    task automatic cycle(input bit rst, input bit c, input logic [31:0] a,
                         input bit inv, input bit rdy, input logic [127:0] md);
        exp_t        e;
        logic [27:0] la;
        int          s;
        int          hw;
        int          wd;
        @(posedge clk);
        #1;
        reset              = rst;
        cs                 = c;
        address            = a;
        invalidate         = inv;
        bus.mem_read_rdy   = rdy;
        bus.mem_bus_data   = md;
        if (!rst) model_reset();

        la = a[31:4];
        s  = int'(la % SETS);
        wd = int'(a[3:2]);
        hw = -1;
        if (rst && c && !m_pending && !inv) begin
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_line[s][w] == la) hw = w;
        end
        e.hit      = (hw >= 0);
        e.data     = (hw >= 0) ? m_data[s][hw][wd*32 +: 32] : 32'h0;
        e.busy     = m_pending;
        e.start    = m_pending;
        e.chk_addr = m_pending || !rst;
        e.addr     = {m_pline, 4'b0};
        e.hc       = m_hits;
        e.mc       = m_misses;
        exp_q.push_back(e);

        if (rst) begin
            if (!m_pending) begin
                if (hw >= 0) begin
                    m_mru[s] = hw;
                    if (m_hits != 32'hFFFFFFFF) m_hits++;
                end else if (c && !inv) begin
                    m_pending = 1'b1;
                    m_pline   = la;
                    m_pinv    = 1'b0;
                    if (m_misses != 32'hFFFFFFFF) m_misses++;
                end
            end else begin
                if (inv) m_pinv = 1'b1;
                if (rdy) begin
                    m_pending = 1'b0;
                    if (!m_pinv) model_install(m_pline, md);
                end
            end
            if (inv) begin
                for (int i = 0; i < SETS; i++) begin
                    m_valid[i][0] = 1'b0;
                    m_valid[i][1] = 1'b0;
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hit", {31'b0, hit}, {31'b0, e.hit});
            check("data", data, e.data);
            check("busy", {31'b0, busy}, {31'b0, e.busy});
            check("mem_read_start", {31'b0, bus.mem_read_start}, {31'b0, e.start});
            if (e.chk_addr) check("mem_bus_address", bus.mem_bus_address, e.addr);
`ifdef ICACHE_PERF_CNT_EN
            check("hit_count", hit_count, e.hc);
            check("miss_count", miss_count, e.mc);
`endif
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic access(input logic [31:0] a);
        cycle(1'b1, 1'b1, a, 1'b0, 1'b0, rnd128());
    endtask

    // Miss on a, one busy cycle, then refill with md
    task automatic fill(input logic [31:0] a, input logic [127:0] md);
        access(a);
        access(a);
        cycle(1'b1, 1'b1, a, 1'b0, 1'b1, md);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset              = 1'b0;
        cs                 = 1'b0;
        address            = '0;
        invalidate         = 1'b0;
        bus.mem_read_rdy   = 1'b0;
        bus.mem_bus_data   = '0;
        model_reset();

        // Reset state
        repeat (3) cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, rnd128());

        // Cold miss on 0x100, then two words of the line
        fill(32'h100, 128'h0000000D_0000000C_0000000B_0000000A);
        access(32'h100);
        access(32'h10C);
        // rdy while idle is ignored
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, rnd128());

        // Two-way fill of set 0, LRU eviction
        fill(32'h000, 128'h13_00000012_00000011_00000010);
        access(32'h100);
        access(32'h004);
        access(32'h000);
        fill(32'h200, 128'h23_00000022_00000021_00000020);
        access(32'h000);
        access(32'h208);
        fill(32'h100, 128'h0000000D_0000000C_0000000B_0000000A);
        access(32'h100);

        // Address change mid-refill
        access(32'h040);
        access(32'h080);
        access(32'h080);
        access(32'h084);
        cycle(1'b1, 1'b1, 32'h080, 1'b0, 1'b1, 128'h43_00000042_00000041_00000040);
        access(32'h080);
        access(32'h080);
        cycle(1'b1, 1'b1, 32'h080, 1'b0, 1'b1, 128'h83_00000082_00000081_00000080);
        access(32'h040);
        access(32'h08C);

        // Invalidate with a line cached, then during a refill
        access(32'h100);
        cycle(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, rnd128());
        fill(32'h100, 128'h0000000D_0000000C_0000000B_0000000A);
        access(32'h100);
        access(32'h200);
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, rnd128());
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, rnd128());
        access(32'h200);

        // Reset mid-refill, later rdy installs nothing
        access(32'h300);
        access(32'h300);
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, rnd128());
        cycle(1'b1, 1'b0, 32'h300, 1'b0, 1'b1, 128'h1);
        access(32'h300);
        cycle(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 128'h33_00000032_00000031_00000030);

`ifdef ICACHE_PERF_CNT_EN
        // One miss then three hit cycles, then saturation by force
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        fill(32'h500, rnd128());
        access(32'h500);
        access(32'h504);
        access(32'h508);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("miss_count_one", miss_count, 32'd1);
        check("hit_count_three", hit_count, 32'd3);
        force dut.hit_count = 32'hFFFFFFFF;
        #1;
        release dut.hit_count;
        m_hits = 32'hFFFFFFFF;
        access(32'h500);
        access(32'h500);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("hit_count_saturated", hit_count, 32'hFFFFFFFF);
`endif

        // Randomized traffic over a few conflicting tags and sets
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          c;
            bit          inv;
            bit          rdy;
            logic [31:0] a;
            r   = ($urandom_range(0, 499) != 0);
            c   = ($urandom_range(0, 4) != 0);
            a   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4)
                | $urandom_range(0, 15);
            inv = ($urandom_range(0, 39) == 0);
            rdy = m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cycle(r, c, a, inv, rdy, rnd128());
        end

        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            check("scoreboard_drained", exp_q.size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
